// File: rtl/iob_eth_rx_unpack_pkg.sv
// ---------------------------------------------------------------------------
// iob_eth_rx_unpack_pkg
// Shared definitions for the Ethernet RX unpacker: FSM state encoding,
// header layout (dest MAC, src MAC, ethertype offsets), the good-FCS CRC
// residue and the payload byte record carried through the skid buffer.
// ---------------------------------------------------------------------------
package iob_eth_rx_unpack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_DONE = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

  localparam int ETH_HDR_LEN  = 14;
  localparam int SRC_MAC_OFS  = 6;
  localparam int SRC_MAC_LEN  = 6;
  localparam int ETH_TYPE_OFS = 12;
  localparam int ETH_TYPE_LEN = 2;

  // CRC register value left behind by a frame whose FCS checked good.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } pay_byte_t;

endpackage

// File: rtl/iob_eth_rx_unpack_skid2.sv
// ---------------------------------------------------------------------------
// iob_eth_skid2
// Two-entry byte buffer (output register + one skid slot) that absorbs the
// 1-cycle buffer read latency so payload can stream at 1 byte/cycle.
// The caller only pushes when it has reserved space (occupancy < 2).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_flush             drop all held bytes
//   i_valid, i_byte     byte returned from the buffer read port
//   i_ready             downstream ready
//   o_valid, o_byte     head byte presented downstream
//   o_cnt               number of bytes held (0..2)
// ---------------------------------------------------------------------------
module iob_eth_skid2
  import iob_eth_rx_unpack_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_flush,
  input  logic      i_valid,
  input  pay_byte_t i_byte,
  input  logic      i_ready,
  output logic      o_valid,
  output pay_byte_t o_byte,
  output logic [1:0] o_cnt
);

  pay_byte_t r_out, r_skid;
  logic      r_out_v, r_skid_v;
  logic      w_pop;

  assign w_pop = r_out_v & i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_skid   <= '0;
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (i_flush) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_pop) begin
      if (r_skid_v) begin
        // skid moves up; an arriving byte refills the skid slot
        r_out    <= r_skid;
        r_skid   <= i_byte;
        r_skid_v <= i_valid;
      end else begin
        r_out   <= i_byte;
        r_out_v <= i_valid;
      end
    end else if (i_valid) begin
      if (!r_out_v) begin
        r_out   <= i_byte;
        r_out_v <= 1'b1;
      end else begin
        r_skid   <= i_byte;
        r_skid_v <= 1'b1;
      end
    end
  end

  assign o_valid = r_out_v;
  assign o_byte  = r_out;
  assign o_cnt   = {1'b0, r_out_v} + {1'b0, r_skid_v};

endmodule

// File: rtl/iob_eth_rx_unpack.sv
// ---------------------------------------------------------------------------
// iob_eth_rx_unpack
// System-clock consumer of the Ethernet receive buffer. Waits for the
// (synchronised) frame-received level, reads the header to capture source
// MAC and ethertype, streams the payload over a valid/ready byte port and
// then runs a 4-phase acknowledge with the receiver.
// Optional CRC status: define IOB_ETH_RX_UNPACK_CRC_CHECK_EN to drive
// crc_err_o from crc_value_i; otherwise crc_err_o is tied low.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   data_rcvd_i / rcv_ack_o     frame-ready level in / acknowledge out
//   crc_value_i, len_i          receiver CRC register, payload length
//   buf_addr_o/buf_rd_o/buf_data_i  1-cycle-latency buffer read port
//   src_mac_o, eth_type_o, hdr_valid_o   captured header
//   m_data_o/m_valid_o/m_ready_i/m_last_o  payload byte stream
//   crc_err_o, frame_done_o     frame status
// ---------------------------------------------------------------------------
module iob_eth_rx_unpack
  import iob_eth_rx_unpack_pkg::*;
#(
  parameter int BUF_AW      = 11,
  parameter int HDR_LEN     = ETH_HDR_LEN,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_rcvd_i,
  output logic              rcv_ack_o,
  input  logic [31:0]       crc_value_i,
  input  logic [10:0]       len_i,
  output logic [BUF_AW-1:0] buf_addr_o,
  output logic              buf_rd_o,
  input  logic [7:0]        buf_data_i,
  output logic [47:0]       src_mac_o,
  output logic [15:0]       eth_type_o,
  output logic              hdr_valid_o,
  output logic [7:0]        m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              crc_err_o,
  output logic              frame_done_o
);

  localparam logic [BUF_AW-1:0] A_HDR_LEN  = BUF_AW'(HDR_LEN);
  localparam logic [BUF_AW-1:0] A_HDR_LAST = BUF_AW'(HDR_LEN - 1);
  localparam logic [BUF_AW-1:0] A_SRC_LO   = BUF_AW'(SRC_MAC_OFS);
  localparam logic [BUF_AW-1:0] A_SRC_HI   = BUF_AW'(SRC_MAC_OFS + SRC_MAC_LEN);
  localparam logic [BUF_AW-1:0] A_TYPE_LO  = BUF_AW'(ETH_TYPE_OFS);
  localparam logic [BUF_AW-1:0] A_TYPE_HI  = BUF_AW'(ETH_TYPE_OFS + ETH_TYPE_LEN);
  localparam logic [10:0]       L_MAX      = 11'(MAX_PAYLOAD);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_sync;
  logic [BUF_AW-1:0] r_rd_ptr, r_end, r_rd_addr_d;
  logic              r_plen_zero;
  logic              r_rd_d, r_rd_pay_d, r_rd_last_d;
  logic [47:0]       r_src_mac;
  logic [15:0]       r_eth_type;
  logic              r_hdr_valid, r_rcv_ack, r_frame_done;

  logic              w_rdy_s, w_rd, w_rd_last, w_xfer, w_hdr_last;
  logic              w_start, w_abort, w_done, w_ack_clr;
  logic [1:0]        w_occ, w_sk_cnt;
  logic [10:0]       w_plen;
  logic              w_sk_valid;
  pay_byte_t         w_sk_byte, w_sk_in;

  assign w_rdy_s    = r_sync[1];
  assign w_plen     = (len_i > L_MAX) ? L_MAX : len_i;
  assign w_xfer     = m_valid_o & m_ready_i;
  assign w_rd_last  = (r_rd_ptr == r_end - BUF_AW'(1));
  assign w_hdr_last = (r_state == ST_HDR) && r_rd_d && (r_rd_addr_d == A_HDR_LAST);
  // Bytes in flight plus held, crediting a byte leaving this cycle so that
  // a steady stream keeps one read outstanding every cycle.
  assign w_occ      = {1'b0, r_rd_d} + w_sk_cnt - {1'b0, w_xfer};

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rdy_s) w_state_nxt = ST_HDR;
      ST_HDR: begin
        if (!w_rdy_s)        w_state_nxt = ST_IDLE;
        else if (w_hdr_last) w_state_nxt = r_plen_zero ? ST_DONE : ST_PAY;
      end
      ST_PAY: begin
        if (w_xfer && m_last_o)
          w_state_nxt = ST_DONE;
        // receiver went away: let the presented byte go, then abandon
        else if (!w_rdy_s && !r_rd_d && (!m_valid_o || w_xfer))
          w_state_nxt = ST_IDLE;
      end
      ST_DONE: w_state_nxt = ST_ACK;
      ST_ACK:  if (!w_rdy_s) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- output / control decode ----
  always_comb begin
    w_rd      = 1'b0;
    w_start   = 1'b0;
    w_abort   = 1'b0;
    w_done    = 1'b0;
    w_ack_clr = 1'b0;
    case (r_state)
      ST_IDLE: w_start = w_rdy_s;
      ST_HDR: begin
        w_rd    = w_rdy_s && (r_rd_ptr < A_HDR_LEN);
        w_abort = !w_rdy_s;
      end
      ST_PAY: begin
        w_rd    = w_rdy_s && (r_rd_ptr < r_end) && (w_occ < 2'd2);
        w_abort = (w_state_nxt == ST_IDLE);
      end
      ST_DONE: w_done    = 1'b1;
      ST_ACK:  w_ack_clr = !w_rdy_s;
      default: ;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync       <= '0;
      r_rd_ptr     <= '0;
      r_end        <= '0;
      r_rd_addr_d  <= '0;
      r_plen_zero  <= 1'b0;
      r_rd_d       <= 1'b0;
      r_rd_pay_d   <= 1'b0;
      r_rd_last_d  <= 1'b0;
      r_src_mac    <= '0;
      r_eth_type   <= '0;
      r_hdr_valid  <= 1'b0;
      r_rcv_ack    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], data_rcvd_i};
      r_rd_d       <= w_rd;
      r_rd_addr_d  <= r_rd_ptr;
      r_rd_pay_d   <= (r_state == ST_PAY);
      r_rd_last_d  <= w_rd_last;
      r_frame_done <= w_done;

      if (w_start) begin
        r_rd_ptr    <= '0;
        r_end       <= A_HDR_LEN + BUF_AW'(w_plen);
        r_plen_zero <= (w_plen == 11'd0);
      end else if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + BUF_AW'(1);
      end

      // dest MAC bytes fall outside both windows and are dropped
      if (r_state == ST_HDR && r_rd_d) begin
        if (r_rd_addr_d >= A_SRC_LO && r_rd_addr_d < A_SRC_HI)
          r_src_mac <= {r_src_mac[39:0], buf_data_i};
        if (r_rd_addr_d >= A_TYPE_LO && r_rd_addr_d < A_TYPE_HI)
          r_eth_type <= {r_eth_type[7:0], buf_data_i};
      end

      if (w_done || w_abort)  r_hdr_valid <= 1'b0;
      else if (w_hdr_last)    r_hdr_valid <= 1'b1;

      if (w_done)         r_rcv_ack <= 1'b1;
      else if (w_ack_clr) r_rcv_ack <= 1'b0;
    end
  end

`ifdef IOB_ETH_RX_UNPACK_CRC_CHECK_EN
  logic r_crc_err;
  always_ff @(posedge clk) begin
    if (!rst_n)       r_crc_err <= 1'b0;
    else if (w_start) r_crc_err <= 1'b0;
    else if (w_done)  r_crc_err <= (crc_value_i != CRC_RESIDUE);
  end
  assign crc_err_o = r_crc_err;
`else
  logic w_unused_crc;
  assign w_unused_crc = ^crc_value_i;
  assign crc_err_o    = 1'b0;
`endif

  assign w_sk_in.last = r_rd_last_d;
  assign w_sk_in.data = buf_data_i;

  iob_eth_skid2 u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_abort),
    .i_valid (r_rd_d & r_rd_pay_d),
    .i_byte  (w_sk_in),
    .i_ready (m_ready_i),
    .o_valid (w_sk_valid),
    .o_byte  (w_sk_byte),
    .o_cnt   (w_sk_cnt)
  );

  assign buf_addr_o   = r_rd_ptr;
  assign buf_rd_o     = w_rd;
  assign src_mac_o    = r_src_mac;
  assign eth_type_o   = r_eth_type;
  assign hdr_valid_o  = r_hdr_valid;
  assign m_valid_o    = w_sk_valid;
  assign m_data_o     = w_sk_byte.data;
  assign m_last_o     = w_sk_valid & w_sk_byte.last;
  assign rcv_ack_o    = r_rcv_ack;
  assign frame_done_o = r_frame_done;

endmodule
